// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types, op codes and helpers for the load/store unit
//
// Purpose: data-memory op codes, widths, LSU state enum, exception cause codes,
//          MMIO region boundary, and small decode helpers.
// Ports:   none (package).
package load_store_unit_pkg;

   localparam int RF_XLEN   = 32;
   localparam int DM_OPSLEN = 3;

   // op[1:0] selects the access size (00 byte, 01 half, 1x word); op[2] marks
   // unsigned loads. Store codes reuse the signed load encodings.
   localparam logic [DM_OPSLEN-1:0] DM_OPS_LB  = 3'b000;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_LH  = 3'b001;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_LW  = 3'b010;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_LBU = 3'b100;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_LHU = 3'b101;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_SB  = 3'b000;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_SH  = 3'b001;
   localparam logic [DM_OPSLEN-1:0] DM_OPS_SW  = 3'b010;

   // Addresses with every bit at or above this position clear belong to data memory.
   localparam int MMIO_REGION_BIT = 10;

   localparam logic [1:0] EXC_LOAD_MISALIGNED  = 2'b00;
   localparam logic [1:0] EXC_STORE_MISALIGNED = 2'b01;
   localparam logic [1:0] EXC_LOAD_FAULT       = 2'b10;
   localparam logic [1:0] EXC_STORE_FAULT      = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'b00,
      LSU_DM_ACC = 2'b01,
      LSU_MMIO   = 2'b10,
      LSU_RESP   = 2'b11
   } lsu_state_t;

   function automatic logic addr_aligned(input logic [DM_OPSLEN-1:0] op, input logic [1:0] lo);
      if (op[1])
         return (lo == 2'b00);
      else if (op[0])
         return !lo[0];
      else
         return 1'b1;
   endfunction

   function automatic logic addr_is_dm(input logic [RF_XLEN-1:0] a);
      return (a[RF_XLEN-1:MMIO_REGION_BIT] == '0);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store lane replication and load shift/extend
//
// Purpose: combinational lane logic for the MMIO path.
// Ports:   op        in  access op code
//          addr_lo   in  byte offset within the word
//          wdata     in  store data (right-justified)
//          rdata     in  word-lane read data
//          be        out byte enables
//          wdata_lanes out store data replicated into the addressed lane(s)
//          rdata_ext out read data shifted down and sign/zero extended
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [DM_OPSLEN-1:0] op,
   input  logic [1:0]           addr_lo,
   input  logic [RF_XLEN-1:0]   wdata,
   input  logic [RF_XLEN-1:0]   rdata,
   output logic [3:0]           be,
   output logic [RF_XLEN-1:0]   wdata_lanes,
   output logic [RF_XLEN-1:0]   rdata_ext
);

   logic [RF_XLEN-1:0] shifted;

   always_comb begin
      be          = 4'b0000;
      wdata_lanes = '0;
      rdata_ext   = '0;
      shifted     = rdata >> {addr_lo, 3'b000};
      if (op[1]) begin
         be          = 4'b1111;
         wdata_lanes = wdata;
         rdata_ext   = shifted;
      end else if (op[0]) begin
         be          = 4'b0011 << addr_lo;
         wdata_lanes = {2{wdata[15:0]}};
         rdata_ext   = op[2] ? {16'h0000, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
      end else begin
         be          = 4'b0001 << addr_lo;
         wdata_lanes = {4{wdata[7:0]}};
         rdata_ext   = op[2] ? {24'h000000, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with data-memory and MMIO paths
//
// Purpose: accepts one load/store at a time from the pipeline, checks alignment,
//          routes it to data memory or the MMIO bus, and reports a writeback
//          result or an exception.
// Ports:   clk, rst                         clock, synchronous active-high reset
//          ex_valid/ex_ready                request handshake
//          ex_is_load, ex_is_store, ex_op   request type and op code
//          ex_addr, ex_wdata, ex_rd         address, store data, load destination
//          dm_*                             data-memory port (active only in DM_ACC)
//          mmio_*                           MMIO bus (held while waiting for ack)
//          wb_valid, wb_rd, wb_data         load writeback pulse
//          exc_valid, exc_cause, exc_addr   exception pulse
//          busy                             high whenever not idle
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic                 ex_is_load,
   input  logic                 ex_is_store,
   input  logic [DM_OPSLEN-1:0] ex_op,
   input  logic [RF_XLEN-1:0]   ex_addr,
   input  logic [RF_XLEN-1:0]   ex_wdata,
   input  logic [4:0]           ex_rd,
   output logic                 dm_rd_en,
   output logic                 dm_wr_en,
   output logic [DM_OPSLEN-1:0] dm_rd_op,
   output logic [DM_OPSLEN-1:0] dm_wr_op,
   output logic [RF_XLEN-1:0]   dm_addr,
   output logic [RF_XLEN-1:0]   dm_wdata,
   input  logic [RF_XLEN-1:0]   dm_rdata,
   input  logic                 dm_valid,
   output logic                 mmio_req,
   output logic                 mmio_we,
   output logic [RF_XLEN-1:0]   mmio_addr,
   output logic [RF_XLEN-1:0]   mmio_wdata,
   output logic [3:0]           mmio_be,
   input  logic [RF_XLEN-1:0]   mmio_rdata,
   input  logic                 mmio_ack,
   output logic                 wb_valid,
   output logic [4:0]           wb_rd,
   output logic [RF_XLEN-1:0]   wb_data,
   output logic                 exc_valid,
   output logic [1:0]           exc_cause,
   output logic [RF_XLEN-1:0]   exc_addr,
   output logic                 busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   lsu_state_t state, state_next;

   logic                 r_store;
   logic [DM_OPSLEN-1:0] r_op;
   logic [RF_XLEN-1:0]   r_addr;
   logic [RF_XLEN-1:0]   r_wdata;
   logic [4:0]           r_rd;
   logic [CNT_W-1:0]     wait_cnt;

   logic accept, req_mem, req_aligned, req_dm, timeout_hit;

   logic [3:0]         al_be;
   logic [RF_XLEN-1:0] al_wdata;
   logic [RF_XLEN-1:0] al_rdata;

   assign accept      = ex_valid && (state == LSU_IDLE);
   assign req_mem     = ex_is_load || ex_is_store;
   assign req_aligned = addr_aligned(ex_op, ex_addr[1:0]);
   assign req_dm      = addr_is_dm(ex_addr);
   // The counter starts at 0 in the first MMIO cycle, so this is the last
   // cycle mmio_req may stay up; an ack arriving here still completes.
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

   lsu_align u_align (
      .op          (r_op),
      .addr_lo     (r_addr[1:0]),
      .wdata       (r_wdata),
      .rdata       (mmio_rdata),
      .be          (al_be),
      .wdata_lanes (al_wdata),
      .rdata_ext   (al_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= LSU_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      ex_ready   = 1'b0;
      busy       = 1'b1;
      dm_rd_en   = 1'b0;
      dm_wr_en   = 1'b0;
      dm_rd_op   = '0;
      dm_wr_op   = '0;
      dm_addr    = '0;
      dm_wdata   = '0;
      mmio_req   = 1'b0;
      mmio_we    = 1'b0;
      mmio_addr  = '0;
      mmio_wdata = '0;
      mmio_be    = 4'b0000;
      case (state)
         LSU_IDLE: begin
            ex_ready = 1'b1;
            busy     = 1'b0;
            if (accept && req_mem && req_aligned)
               state_next = req_dm ? LSU_DM_ACC : LSU_MMIO;
         end
         LSU_DM_ACC: begin
            dm_rd_en   = !r_store;
            dm_wr_en   = r_store;
            dm_rd_op   = r_store ? '0 : r_op;
            dm_wr_op   = r_store ? r_op : '0;
            dm_addr    = r_addr;
            dm_wdata   = r_store ? r_wdata : '0;
            state_next = LSU_RESP;
         end
         LSU_MMIO: begin
            mmio_req   = 1'b1;
            mmio_we    = r_store;
            mmio_addr  = {r_addr[RF_XLEN-1:2], 2'b00};
            mmio_be    = al_be;
            mmio_wdata = r_store ? al_wdata : '0;
            if (mmio_ack)
               state_next = LSU_RESP;
            else if (timeout_hit)
               state_next = LSU_IDLE;
         end
         LSU_RESP: begin
            state_next = LSU_IDLE;
         end
         default: begin
            state_next = LSU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_store   <= 1'b0;
         r_op      <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd      <= '0;
         wait_cnt  <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         exc_valid <= 1'b0;
         exc_cause <= '0;
         exc_addr  <= '0;
      end else begin
         wb_valid  <= 1'b0;
         exc_valid <= 1'b0;
         case (state)
            LSU_IDLE: begin
               if (accept && req_mem) begin
                  // A request with both type bits set is treated as a store.
                  r_store  <= ex_is_store;
                  r_op     <= ex_op;
                  r_addr   <= ex_addr;
                  r_wdata  <= ex_wdata;
                  r_rd     <= ex_rd;
                  wait_cnt <= '0;
                  if (!req_aligned) begin
                     exc_valid <= 1'b1;
                     exc_cause <= ex_is_store ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
                     exc_addr  <= ex_addr;
                  end
               end
            end
            LSU_DM_ACC: begin
               if (!r_store) begin
                  if (dm_valid) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= r_rd;
                     wb_data  <= dm_rdata;
                  end else begin
                     exc_valid <= 1'b1;
                     exc_cause <= EXC_LOAD_FAULT;
                     exc_addr  <= r_addr;
                  end
               end
            end
            LSU_MMIO: begin
               if (mmio_ack) begin
                  if (!r_store) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= r_rd;
                     wb_data  <= al_rdata;
                  end
               end else if (timeout_hit) begin
                  exc_valid <= 1'b1;
                  exc_cause <= r_store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                  exc_addr  <= r_addr;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
   logic [2:0]  ex_op;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic        dm_rd_en, dm_wr_en;
   logic [2:0]  dm_rd_op, dm_wr_op;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_valid;
   logic        mmio_req, mmio_we;
   logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
   logic [3:0]  mmio_be;
   logic        mmio_ack;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;
   logic        busy;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_op(ex_op),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_rd_op(dm_rd_op), .dm_wr_op(dm_wr_op),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
      .mmio_wdata(mmio_wdata), .mmio_be(mmio_be),
      .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] mem    [0:1023];  // slave storage, written through the DUT's dm port
   logic [7:0] shadow [0:1023];  // what memory should hold after each intended store

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] op);
      case (op[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] v);
      case (op)
         DM_OPS_LB:  return {{24{v[7]}}, v[7:0]};
         DM_OPS_LBU: return {24'h0, v[7:0]};
         DM_OPS_LH:  return {{16{v[15]}}, v[15:0]};
         DM_OPS_LHU: return {16'h0, v[15:0]};
         default:    return v;
      endcase
   endfunction

   function automatic logic [31:0] gather(input bit from_shadow, input logic [31:0] a, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++)
         v[8*i +: 8] = from_shadow ? shadow[(a[9:0] + i) % 1024] : mem[(a[9:0] + i) % 1024];
      return v;
   endfunction

   task automatic do_op(input logic ld, input logic st, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int ack_cycle, input logic [31:0] mrd);
      int n, lane;
      logic is_mem, aligned, in_dm;
      logic [31:0] exp, exp_w, mask;
      logic [3:0]  exp_be;
      n       = nbytes(op);
      is_mem  = ld | st;
      aligned = (addr % n) == 0;
      in_dm   = addr < 32'd1024;

      @(negedge clk);
      check("ready_before", ex_ready, 1);
      ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_op = op;
      ex_addr = addr; ex_wdata = wd; ex_rd = rd;
      @(negedge clk);
      ex_valid = 0; ex_is_load = 0; ex_is_store = 0;

      if (!is_mem) begin
         check("noop_busy", busy, 0);
         check("noop_exc", exc_valid, 0);
         check("noop_access", dm_rd_en | dm_wr_en | mmio_req, 0);
         return;
      end
      if (!aligned) begin
         check("mis_exc", exc_valid, 1);
         check("mis_cause", exc_cause, {1'b0, st});
         check("mis_addr", exc_addr, addr);
         check("mis_access", dm_rd_en | dm_wr_en | mmio_req, 0);
         check("mis_busy", busy, 0);
         return;
      end

      if (in_dm) begin
         check("dm_rd_en", dm_rd_en, !st);
         check("dm_wr_en", dm_wr_en, st);
         check("dm_addr", dm_addr, addr);
         check("dm_ready", ex_ready, 0);
         if (st) begin
            check("dm_wr_op", dm_wr_op, op);
            for (int i = 0; i < nbytes(dm_wr_op); i++)
               mem[(dm_addr[9:0] + i) % 1024] = dm_wdata[8*i +: 8];
            for (int i = 0; i < n; i++)
               shadow[(addr[9:0] + i) % 1024] = wd[8*i +: 8];
         end else begin
            exp = ext(op, gather(1, addr, n));
            dm_rdata = ext(dm_rd_op, gather(0, dm_addr, nbytes(dm_rd_op)));
         end
         @(negedge clk);
         check("resp_ready", ex_ready, 0);
         if (!st && dm_valid) begin
            check("dm_wb_valid", wb_valid, 1);
            check("dm_wb_data", wb_data, exp);
            check("dm_wb_rd", wb_rd, rd);
            check("dm_wb_exc", exc_valid, 0);
         end else if (!st) begin
            check("dm_fault_exc", exc_valid, 1);
            check("dm_fault_cause", exc_cause, 2'b10);
            check("dm_fault_addr", exc_addr, addr);
            check("dm_fault_wb", wb_valid, 0);
         end else begin
            check("dm_st_wb", wb_valid, 0);
            check("dm_st_exc", exc_valid, 0);
         end
         @(negedge clk);
         check("dm_ready_after", ex_ready, 1);
         check("dm_wb_pulse", wb_valid | exc_valid, 0);
         return;
      end

      exp_be = '0; exp_w = '0; mask = '0;
      for (int i = 0; i < n; i++) begin
         lane = int'(addr % 4) + i;
         exp_be[lane] = 1'b1;
         exp_w[8*lane +: 8] = wd[8*i +: 8];
      end
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{exp_be[i]}};
      exp = ext(op, mrd >> (8 * (addr % 4)));

      for (int c = 1; c <= TO; c++) begin
         check("mmio_req", mmio_req, 1);
         check("mmio_addr", mmio_addr, addr & ~32'h3);
         check("mmio_be", mmio_be, exp_be);
         check("mmio_we", mmio_we, st);
         if (st) check("mmio_wdata", mmio_wdata & mask, exp_w);
         check("mmio_wait_out", wb_valid | exc_valid | ex_ready, 0);
         if (c == ack_cycle) begin
            mmio_rdata = mrd;
            mmio_ack = 1;
         end
         @(negedge clk);
         mmio_ack = 0;
         if (c == ack_cycle) break;
      end

      if (ack_cycle >= 1 && ack_cycle <= TO) begin
         check("mmio_req_drop", mmio_req, 0);
         check("mmio_resp_busy", busy, 1);
         check("mmio_wb_valid", wb_valid, !st);
         if (!st) begin
            check("mmio_wb_data", wb_data, exp);
            check("mmio_wb_rd", wb_rd, rd);
         end
         check("mmio_resp_exc", exc_valid, 0);
         @(negedge clk);
         check("mmio_ready_after", ex_ready, 1);
         check("mmio_wb_pulse", wb_valid, 0);
      end else begin
         check("to_req_drop", mmio_req, 0);
         check("to_exc", exc_valid, 1);
         check("to_cause", exc_cause, {1'b1, st});
         check("to_addr", exc_addr, addr);
         check("to_ready", ex_ready, 1);
         check("to_wb", wb_valid, 0);
         mmio_rdata = mrd;
         mmio_ack = 1;
         @(negedge clk);
         mmio_ack = 0;
         check("late_ack_wb", wb_valid, 0);
         check("late_ack_exc", exc_valid, 0);
         check("late_ack_busy", busy, 0);
      end
   endtask

   initial begin
      logic [2:0] lops [5];
      logic [2:0] sops [3];
      logic [31:0] a;
      logic st, ld;
      lops = '{DM_OPS_LB, DM_OPS_LH, DM_OPS_LW, DM_OPS_LBU, DM_OPS_LHU};
      sops = '{DM_OPS_SB, DM_OPS_SH, DM_OPS_SW};
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 8'($urandom);
         shadow[i] = mem[i];
      end

      rst = 1; ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_op = '0;
      ex_addr = '0; ex_wdata = '0; ex_rd = '0;
      dm_rdata = '0; dm_valid = 1; mmio_rdata = '0; mmio_ack = 0;
      repeat (2) @(negedge clk);
      check("rst_ready", ex_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_dm", {dm_rd_en, dm_wr_en, dm_rd_op, dm_wr_op}, 0);
      check("rst_dm_addr", dm_addr | dm_wdata, 0);
      check("rst_mmio", {mmio_req, mmio_we, mmio_be}, 0);
      check("rst_mmio_bus", mmio_addr | mmio_wdata, 0);
      check("rst_wb", {wb_valid, wb_rd}, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_exc", {exc_valid, exc_cause}, 0);
      check("rst_exc_addr", exc_addr, 0);
      rst = 0;

      do_op(0, 1, DM_OPS_SW, 32'h10, 32'hDEADBEEF, 0, 0, 0);
      do_op(1, 0, DM_OPS_LW, 32'h10, 0, 5'd5, 0, 0);
      do_op(0, 1, DM_OPS_SH, 32'h3, 32'h1234, 0, 0, 0);
      do_op(1, 0, DM_OPS_LW, 32'h2, 0, 5'd3, 0, 0);
      do_op(0, 0, DM_OPS_LW, 32'h40, 0, 5'd1, 0, 0);
      dm_valid = 0;
      do_op(1, 0, DM_OPS_LW, 32'h20, 0, 5'd7, 0, 0);
      dm_valid = 1;
      do_op(1, 0, DM_OPS_LB, 32'h4000_0002, 0, 5'd9, TO, 32'h0080FF11);
      do_op(0, 1, DM_OPS_SB, 32'h4000_0001, 32'hAB, 0, 2, 32'h0);
      do_op(1, 0, DM_OPS_LW, 32'h4000_0000, 0, 5'd2, 0, 32'h55AA55AA);
      do_op(0, 1, DM_OPS_SW, 32'h4000_0100, 32'hCAFEF00D, 0, 0, 32'h0);
      do_op(1, 1, DM_OPS_SB, 32'h37, 32'h5A, 5'd4, 0, 0);
      do_op(1, 0, DM_OPS_LBU, 32'h37, 0, 5'd4, 0, 0);

      @(negedge clk);
      ex_valid = 1; ex_is_load = 1; ex_op = DM_OPS_LW; ex_addr = 32'h4000_0000;
      @(negedge clk);
      ex_valid = 0; ex_is_load = 0;
      check("rst_mid_req", mmio_req, 1);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("rst_mid_req_drop", mmio_req, 0);
      check("rst_mid_ready", ex_ready, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_report", wb_valid | exc_valid, 0);
      rst = 0;
      @(negedge clk);
      check("rst_mid_after", wb_valid | exc_valid | busy, 0);

      for (int k = 0; k < 60; k++) begin
         st = 1'($urandom_range(0, 1));
         ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
         if ($urandom_range(0, 15) == 0) begin ld = 0; st = 0; end
         if ($urandom_range(0, 3) == 0)
            a = 32'h4000_0000 | ($urandom & 32'hFFF);
         else begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
         end
         do_op(ld, st, st ? sops[$urandom_range(0, 2)] : lops[$urandom_range(0, 4)],
               a, $urandom, 5'($urandom), $urandom_range(0, TO), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the maximum number of MMIO cycles to wait for mmio_ack before an access fault is raised.
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 ex_valid/ex_ready  in/out  1/1  pipeline request handshake; a request transfers when both are high.
REQ-005 ex_is_load, ex_is_store  in  1 each  request type; if both are high, the request is a store.
REQ-006 ex_op  in  DM_OPSLEN  DM_OPS_* code; read as a load op for loads and a store op for stores.
REQ-007 ex_addr, ex_wdata  in  RF_XLEN  byte address and store data; ex_rd  in  5  load destination register.
REQ-008 dm_rd_en, dm_wr_en  out  1; dm_rd_op, dm_wr_op  out  DM_OPSLEN; dm_addr, dm_wdata  out  RF_XLEN  data memory port.
REQ-009 dm_rdata  in  RF_XLEN  combinational, already-extended load data; dm_valid  in  1  read-data valid.
REQ-010 mmio_req, mmio_we  out  1; mmio_addr (word-aligned), mmio_wdata  out  RF_XLEN; mmio_be  out  4  MMIO bus outputs.
REQ-011 mmio_rdata  in  RF_XLEN  word-lane read data; mmio_ack  in  1  one-cycle completion pulse.
REQ-012 wb_valid  out  1, wb_rd  out  5, wb_data  out  RF_XLEN  load writeback result.
REQ-013 exc_valid  out  1, exc_cause  out  2, exc_addr  out  RF_XLEN  exception report.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 States: IDLE, DM_ACC, MMIO, RESP; ex_ready = (state==IDLE).
REQ-016 Region decode: addresses with addr[31:10]==0 go to data memory; all other addresses go to MMIO.
REQ-017 Alignment rules: halfword ops require addr[0]==0; word ops require addr[1:0]==0; byte ops are always aligned.
REQ-018 On a misaligned accept, the FSM stays in IDLE, issues no memory or MMIO access, and pulses exc_valid for one cycle in the next cycle with exc_addr=ex_addr.
REQ-019 Exception cause encoding: 00 load misaligned, 01 store misaligned, 10 load access fault, 11 store access fault.
REQ-020 An accept with ex_valid high but neither ex_is_load nor ex_is_store high is a no-op: no outputs, state stays IDLE.
REQ-021 Data-memory accept: IDLE->DM_ACC for exactly one cycle, driving dm_* from registered request fields.
REQ-022 In DM_ACC, a store writes at the edge that ends DM_ACC.
REQ-023 In DM_ACC, a load captures dm_rdata at the end of DM_ACC if dm_valid=1; if dm_valid=0, it raises a load access fault.
REQ-024 DM_ACC->RESP; in RESP, wb_valid pulses for loads only, and the next edge returns to IDLE.
REQ-025 Data-memory load latency is accept edge + 2 cycles to wb_valid; ex_ready is low in DM_ACC and RESP.
REQ-026 dm_rd_en and dm_wr_en are never high together, and both are low outside DM_ACC.
REQ-027 MMIO accept: IDLE->MMIO with mmio_req high and all mmio_* held stable until mmio_ack or timeout.
REQ-028 mmio_be is SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
REQ-029 mmio_wdata carries the store data replicated into the addressed lane(s).
REQ-030 MMIO loads shift mmio_rdata right by 8*addr[1:0], then sign- or zero-extend per LB/LBU/LH/LHU/LW.
REQ-031 On mmio_ack, the load data is captured, mmio_req drops on the next edge, and the FSM goes MMIO->RESP.
REQ-032 A wait counter resets on entry to MMIO and increments each cycle without ack.
REQ-033 When the wait counter reaches TIMEOUT, mmio_req drops, an access fault is raised, and the FSM returns to IDLE; an ack in the same cycle as the timeout wins.
REQ-034 mmio_ack is ignored in any state other than MMIO.
REQ-035 wb_valid and exc_valid are never high in the same cycle, and each is a single-cycle pulse.

Reset
REQ-036 rst forces IDLE at the next edge, including mid-MMIO, and no wb or exc is reported for an aborted request.
REQ-037 All outputs are 0 after reset, except ex_ready=1.

Structure
REQ-038 The shared RISCV_defs.svh holds the DM_OPS_* codes, DM_OPSLEN, RF_XLEN, the LSU state enum, the exception cause codes, and the MMIO region boundary bit (10).
REQ-039 The byte-lane shift/extend and byte-enable generation are a combinational sub-module named lsu_align, used for the MMIO path.

Verification
REQ-040 LW at 0x10 from data memory holding 0xDEADBEEF -> wb_valid 2 cycles after accept with wb_data=0xDEADBEEF; ex_ready low for 2 cycles.
REQ-041 SH at 0x3 -> exc_valid with cause 01 and exc_addr 0x3; dm_wr_en and mmio_req stay 0.
REQ-042 LB at 0x40000002 with mmio_rdata 0x0080FF11 and ack after 3 cycles -> mmio_addr 0x40000000, wb_data 0xFFFFFF80.
REQ-043 SB at 0x40000001, wdata 0xAB -> mmio_be 0010, mmio_wdata lane1=0xAB, mmio_we=1, no wb_valid.
REQ-044 MMIO LW with no ack and TIMEOUT=4 -> mmio_req drops after 4 cycles, exc cause 10; a later ack is ignored.
REQ-045 rst asserted on the second MMIO wait cycle -> IDLE and mmio_req=0 after the edge, no wb or exc, ex_ready=1.
